// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud divisor helper, reused by the receiver.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } uart_state_e;

   // Clock cycles per serial bit; integer division, any remainder is dropped.
   function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
      return clk_freq / uart_bps;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock synchronous FIFO for the UART transmitter; registered full/empty flags.
// push is ignored while full, pop is ignored while empty; rd_data shows the head entry.
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
   logic             wr_en, rd_en;

   assign wr_en     = push & ~full;
   assign rd_en     = pop & ~empty;
   assign wr_ptr_nx = wr_en ? wr_ptr + PTR_ONE : wr_ptr;
   assign rd_ptr_nx = rd_en ? rd_ptr + PTR_ONE : rd_ptr;
   assign rd_data   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   // Flags are computed from the next pointers so they are registered yet current.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         wr_ptr <= wr_ptr_nx;
         rd_ptr <= rd_ptr_nx;
         empty  <= (wr_ptr_nx == rd_ptr_nx);
         full   <= (wr_ptr_nx[AW] != rd_ptr_nx[AW]) &&
                   (wr_ptr_nx[AW-1:0] == rd_ptr_nx[AW-1:0]);
      end
   end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: 8N1 frames from a FIFO, back-to-back with no idle gap.
// Define UART_TX_PARITY_EN to insert an even-parity bit between bit 7 and the stop bit.
module uart_tx
   import uart_pkg::*;
#(
   parameter int UART_BPS   = 115200,
   parameter int CLK_FREQ   = 50_000_000,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  pi_data,
   input  logic        pi_flag,
   output logic        tx,
   output logic        busy,
   output logic        full,
   output logic        overflow,
   output uart_state_e dbg_state
);

   localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
   localparam int CNT_W = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);

   uart_state_e      state, state_nx;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       frame_data;
   logic [7:0]       fifo_rd_data;
   logic             fifo_empty, fifo_pop;
   logic             baud_last, tx_nx;

   uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (pi_flag),
      .wr_data (pi_data),
      .pop     (fifo_pop),
      .rd_data (fifo_rd_data),
      .full    (full),
      .empty   (fifo_empty)
   );

   assign baud_last = (baud_cnt == CNT_LAST);
   assign busy      = (state != IDLE) | ~fifo_empty;
   assign dbg_state = state;

   // tx_nx is the line level for the current state; it is registered one cycle later.
   always_comb begin
      state_nx = state;
      fifo_pop = 1'b0;
      tx_nx    = 1'b1;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               state_nx = START;
            end
         end
         START: begin
            tx_nx = 1'b0;
            if (baud_last) state_nx = DATA;
         end
         DATA: begin
            tx_nx = frame_data[bit_idx];
            if (baud_last && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               state_nx = PARITY;
`else
               state_nx = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            tx_nx = ^frame_data;
            if (baud_last) state_nx = STOP;
         end
`endif
         STOP: begin
            tx_nx = 1'b1;
            if (baud_last) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  state_nx = START;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         frame_data <= '0;
         tx         <= 1'b1;
         overflow   <= 1'b0;
      end else begin
         state    <= state_nx;
         tx       <= tx_nx;
         overflow <= pi_flag & full;
         if (fifo_pop) frame_data <= fifo_rd_data;
         // STOP->START counts as a state entry even though it leaves and re-enters framing.
         if (state_nx != state || baud_last) baud_cnt <= '0;
         else if (state != IDLE)             baud_cnt <= baud_cnt + 1'b1;
         if (state != DATA)  bit_idx <= '0;
         else if (baud_last) bit_idx <= bit_idx + 3'd1;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a default-rate lane and a 10-cycle-per-bit lane, each checked every cycle
// against a queue-based line model, plus directed literal checks. Honours UART_TX_PARITY_EN.
module tb_uart_tx;
   import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int DEPTH = 16;
   localparam int B0    = 50_000_000 / 115200;
   localparam int B1    = 1000 / 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  pi_data = 8'h00;
   logic [1:0]  pi_flag = 2'b00;
   logic [1:0]  tx, busy, full, overflow;
   uart_state_e dbg_state [2];

   int checks = 0;
   int errors = 0;
   logic [7:0] wq[$];
   logic [7:0] got_q[$];

   always #5 clk = ~clk;

   function automatic bit frame_bit(input logic [7:0] d, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return d[i-1];
      if (i == NB - 1) return 1'b1;
      return ^d;
   endfunction

   function automatic int baud_of(input int ln);
      return (ln == 0) ? B0 : B1;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Line model: accepted bytes queue, and the current frame expanded to one entry per cycle.
   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int CF  = (g == 0) ? 50_000_000 : 1000;
      localparam int BPS = (g == 0) ? 115200 : 100;
      localparam int BD  = CF / BPS;

      uart_tx #(.UART_BPS(BPS), .CLK_FREQ(CF), .FIFO_DEPTH(DEPTH)) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .pi_data   (pi_data),
         .pi_flag   (pi_flag[g]),
         .tx        (tx[g]),
         .busy      (busy[g]),
         .full      (full[g]),
         .overflow  (overflow[g]),
         .dbg_state (dbg_state[g])
      );

      logic [7:0] fq[$];
      bit         sq[$];
      bit         m_tx = 1'b1;
      bit         m_pend = 1'b1;
      bit         m_ovf = 1'b0;

      always @(posedge clk or negedge rst_n) begin : model
         bit         full_b, ne_b;
         logic [7:0] b;
         if (!rst_n) begin
            fq.delete();
            sq.delete();
            m_tx   = 1'b1;
            m_pend = 1'b1;
            m_ovf  = 1'b0;
         end else begin
            full_b = (fq.size() == DEPTH);
            ne_b   = (fq.size() != 0);
            m_tx   = m_pend;
            m_ovf  = pi_flag[g] && full_b;
            if (sq.size() != 0) void'(sq.pop_front());
            if (sq.size() == 0 && ne_b) begin
               b = fq.pop_front();
               for (int i = 0; i < NB; i++)
                  for (int c = 0; c < BD; c++) sq.push_back(frame_bit(b, i));
            end
            if (pi_flag[g] && !full_b) fq.push_back(pi_data);
            m_pend = (sq.size() != 0) ? sq[0] : 1'b1;
         end
      end

      always @(negedge clk) begin : compare
         bit e_busy, e_full;
         e_busy = (sq.size() != 0) || (fq.size() != 0);
         e_full = (fq.size() == DEPTH);
         checks++;
         if (tx[g] !== m_tx || busy[g] !== e_busy || full[g] !== e_full || overflow[g] !== m_ovf) begin
            errors++;
            if (errors < 20)
               $display("FAIL lane%0d_cycle t=%0t: got tx=%b busy=%b full=%b ovf=%b, expected tx=%b busy=%b full=%b ovf=%b",
                        g, $time, tx[g], busy[g], full[g], overflow[g], m_tx, e_busy, e_full, m_ovf);
         end
      end
   end

   task automatic write_burst(input int ln);
      foreach (wq[i]) begin
         @(negedge clk);
         pi_data     = wq[i];
         pi_flag[ln] = 1'b1;
      end
      @(negedge clk);
      pi_flag = 2'b00;
   endtask

   task automatic wait_start(input int ln, input int limit, output int n);
      n = 0;
      while (tx[ln] !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("start_seen", int'(tx[ln]), 0);
   endtask

   task automatic wait_idle(input int ln);
      int n;
      n = 0;
      while (busy[ln] !== 1'b0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", int'(busy[ln]), 0);
      repeat (3) @(negedge clk);
   endtask

   // Entered on the cycle a frame's start bit first appears; samples mid-bit until the line idles.
   task automatic decode(input int ln, output int nf);
      int         b;
      logic [7:0] d;
      b  = baud_of(ln);
      nf = 0;
      got_q.delete();
      for (int f = 0; f < 40; f++) begin
         repeat (b / 2) @(negedge clk);
         if (tx[ln] !== 1'b0) break;
         for (int j = 0; j < 8; j++) begin
            repeat (b) @(negedge clk);
            d[j] = tx[ln];
         end
`ifdef UART_TX_PARITY_EN
         repeat (b) @(negedge clk);
         check("parity_bit", int'(tx[ln]), int'(^d));
`endif
         repeat (b) @(negedge clk);
         check("stop_bit", int'(tx[ln]), 1);
         got_q.push_back(d);
         nf++;
         repeat (b - b / 2) @(negedge clk);
      end
   endtask

   initial begin : watchdog
      #2_000_000;
      errors++;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : stimulus
      int n, nf, cnt, bad;
`ifdef UART_TX_PARITY_EN
      int a5_frame[NB] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
      int a5_frame[NB] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif

      // Reset values
      repeat (3) @(negedge clk);
      for (int l = 0; l < 2; l++) begin
         check("reset_tx", int'(tx[l]), 1);
         check("reset_busy", int'(busy[l]), 0);
         check("reset_full", int'(full[l]), 0);
         check("reset_ovf", int'(overflow[l]), 0);
         check("reset_state", int'(dbg_state[l]), int'(IDLE));
      end
      #2 rst_n = 1'b1;

      // 0xA5 while idle: latency, literal frame, start-bit length, busy after stop
      wq = '{8'hA5};
      write_burst(0);
      wait_start(0, 10, n);
      check("a5_start_latency", n, 2);
      repeat (B0 - 1) @(negedge clk);
      check("a5_start_last_cycle", int'(tx[0]), 0);
      @(negedge clk);
      check("a5_bit0_first_cycle", int'(tx[0]), 1);
      repeat (B0 / 2) @(negedge clk);
      check("a5_bit1", int'(tx[0]), a5_frame[1]);
      for (int j = 2; j < NB; j++) begin
         repeat (B0) @(negedge clk);
         check($sformatf("a5_bit%0d", j), int'(tx[0]), a5_frame[j]);
      end
      repeat (B0 - B0 / 2) @(negedge clk);
      check("a5_busy_after_stop", int'(busy[0]), 0);
      check("a5_tx_idle", int'(tx[0]), 1);
      wait_idle(0);

`ifdef UART_TX_PARITY_EN
      // 0x07 has three ones: parity bit 1
      wq = '{8'h07};
      write_burst(0);
      wait_start(0, 10, n);
      repeat (9 * B0 + B0 / 2) @(negedge clk);
      check("p07_parity", int'(tx[0]), 1);
      wait_idle(0);
`endif

      // Back-to-back on the default lane: exact total busy span
      wq = '{8'h00, 8'hFF, 8'h55};
      write_burst(0);
      wait_start(0, 10, n);
      cnt = 0;
      while (busy[0] === 1'b1 && cnt < 3 * NB * B0 + 100) begin
         @(negedge clk);
         cnt++;
      end
      check("b2b_total_cycles", cnt + 1, 3 * NB * B0);
      wait_idle(0);

      // Back-to-back on the fast lane: three contiguous frames decoded
      write_burst(1);
      wait_start(1, 10, n);
      decode(1, nf);
      check("b2b_frames", nf, 3);
      foreach (wq[i])
         if (i < got_q.size()) check($sformatf("b2b_byte%0d", i), int'(got_q[i]), int'(wq[i]));
      wait_idle(1);

      // 18 consecutive writes: 17 accepted, full, overflow pulse, 17 frames
      fork
         begin
            for (int i = 0; i < 18; i++) begin
               @(negedge clk);
               if (i == 16) check("full_before_17th", int'(full[1]), 0);
               if (i == 17) begin
                  check("full_after_17", int'(full[1]), 1);
                  check("ovf_not_yet", int'(overflow[1]), 0);
               end
               pi_data    = 8'(i);
               pi_flag[1] = 1'b1;
            end
            @(negedge clk);
            pi_flag = 2'b00;
            check("ovf_pulse", int'(overflow[1]), 1);
            check("full_held", int'(full[1]), 1);
            @(negedge clk);
            check("ovf_one_cycle", int'(overflow[1]), 0);
         end
         begin
            int m, k;
            wait_start(1, 60, m);
            decode(1, k);
            check("ovf_frames", k, 17);
         end
      join
      for (int i = 0; i < 17; i++)
         if (i < got_q.size()) check($sformatf("ovf_byte%0d", i), int'(got_q[i]), i);
      wait_idle(1);

      // Reduced clock: start bit of 0x01 is low for exactly 10 cycles
      wq = '{8'h01};
      write_burst(1);
      wait_start(1, 10, n);
      cnt = 0;
      while (tx[1] === 1'b0 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      check("small_bit_period", cnt, 10);
      wait_idle(1);

      // Reset in bit 4 of 0x3C with two bytes queued
      wq = '{8'h3C, 8'h11, 8'h22};
      write_burst(0);
      wait_start(0, 10, n);
      repeat (5 * B0 + B0 / 2) @(negedge clk);
      check("rst_pre_bit4", int'(tx[0]), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_tx_now", int'(tx[0]), 1);
      check("rst_busy_now", int'(busy[0]), 0);
      check("rst_full_now", int'(full[0]), 0);
      check("rst_state_now", int'(dbg_state[0]), int'(IDLE));
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 3 * B0; i++) begin
         @(negedge clk);
         if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
      end
      check("rst_no_frames_after", bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
